// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: forwarding-select encoding,
// pipeline shadow entry, register address width and a match helper.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_RF     = 2'b00,
        FWD_MEM_WB = 2'b01,
        FWD_EX_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  is_load;
    } shadow_t;

    // A source hits a stage when that stage will write the same
    // nonzero register.
    function automatic logic src_hit(
        input logic [REG_ADDR_W-1:0] rs,
        input shadow_t               e
    );
        return e.valid && e.reg_write && (rs != '0) && (rs == e.rd);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request and hazard response bundle.
// master: decode/pipeline side (drives id_*, flush); slave: scoreboard.
interface hazard_scoreboard_if
    import hazard_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int LAT_W   = 5
);

    logic                                  id_valid;
    logic [NUM_SRC-1:0][REG_ADDR_W-1:0]    id_rs;
    logic [NUM_SRC-1:0]                    id_rs_used;
    logic [REG_ADDR_W-1:0]                 id_rd;
    logic                                  id_reg_write;
    logic                                  id_is_load;
    logic                                  id_is_mc;
    logic [LAT_W-1:0]                      id_mc_lat;
    logic                                  flush;
    logic                                  stall;
    logic [NUM_SRC-1:0][1:0]               ex_fwd_sel;
    logic                                  mc_busy;
    logic                                  mc_done;
    logic [REG_ADDR_W-1:0]                 mc_rd;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_reg_write,
        output id_is_load, id_is_mc, id_mc_lat, flush,
        input  stall, ex_fwd_sel, mc_busy, mc_done, mc_rd
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_reg_write,
        input  id_is_load, id_is_mc, id_mc_lat, flush,
        output stall, ex_fwd_sel, mc_busy, mc_done, mc_rd
    );

endinterface

// File: rtl/hazard_mc_tracker.sv
// Multi-cycle (mul/div) occupancy tracker.
// Ports: clk, rst, start/lat/rd (op entering EX), busy, done (1-cycle), busy_rd.
module hazard_mc_tracker
    import hazard_pkg::*;
#(
    parameter int LAT_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LAT_W-1:0]      lat,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic                  busy,
    output logic                  done,
    output logic [REG_ADDR_W-1:0] busy_rd
);

    logic [LAT_W-1:0] cnt;
    logic [LAT_W-1:0] lat_m1;

    // Latency 0 behaves as latency 1.
    assign lat_m1 = (lat == '0) ? '0 : lat - LAT_W'(1);

    // cnt holds the edges remaining before done is raised; a start on
    // the edge that ends a done cycle takes precedence over clearing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            busy_rd <= '0;
            cnt     <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            busy_rd <= rd;
            cnt     <= lat_m1;
            done    <= (lat_m1 == '0);
        end else if (done) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else if (busy) begin
            if (cnt == LAT_W'(1)) begin
                done <= 1'b1;
            end
            cnt <= cnt - LAT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: load-use / multi-cycle stall and EX forwarding select.
// Ports: clk, rst, bus (hazard_scoreboard_if.slave); with HAZARD_PERF_CNT_EN
// defined also perf_lu_stalls, perf_mc_stalls (saturating stall counters).
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int LAT_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]        perf_lu_stalls,
    output logic [31:0]        perf_mc_stalls
`endif
);

    shadow_t                 ex_q;
    shadow_t                 mem_q;
    shadow_t                 wb_q;
    shadow_t                 ex_nxt;
    logic [NUM_SRC-1:0][1:0] fwd_q;
    logic [NUM_SRC-1:0][1:0] fwd_nxt;
    fwd_sel_e                sel;

    logic                    mc_busy;
    logic                    mc_done;
    logic [REG_ADDR_W-1:0]   mc_rd;
    logic                    mc_open;
    logic                    lu_hit;
    logic                    mc_hit;
    logic                    req;
    logic                    stall;
    logic                    issue;

    // The done cycle already frees the unit for readers and a new op.
    assign mc_open = mc_busy & ~mc_done;
    assign req     = ~rst & bus.id_valid & ~bus.flush;
    assign stall   = req & (lu_hit | mc_hit);
    assign issue   = req & ~stall;

    always_comb begin
        lu_hit = 1'b0;
        mc_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.id_rs_used[i] && bus.id_rs[i] != '0) begin
                if (ex_q.valid && ex_q.is_load && bus.id_rs[i] == ex_q.rd) begin
                    lu_hit = 1'b1;
                end
                if (mc_open && bus.id_rs[i] == mc_rd) begin
                    mc_hit = 1'b1;
                end
            end
        end
        if (mc_open && bus.id_reg_write && bus.id_rd != '0 && bus.id_rd == mc_rd) begin
            mc_hit = 1'b1;
        end
        if (mc_open && bus.id_is_mc) begin
            mc_hit = 1'b1;
        end
    end

    // Current EX becomes EX/MEM and current MEM becomes MEM/WB when the
    // ID instruction moves into EX; the youngest producer wins.
    always_comb begin
        fwd_nxt = '0;
        sel     = FWD_RF;
        for (int i = 0; i < NUM_SRC; i++) begin
            sel = FWD_RF;
            if (bus.id_rs_used[i]) begin
                if (src_hit(bus.id_rs[i], ex_q)) begin
                    sel = FWD_EX_MEM;
                end else if (src_hit(bus.id_rs[i], mem_q)) begin
                    sel = FWD_MEM_WB;
                end else if (src_hit(bus.id_rs[i], wb_q)) begin
                    // Retiring write lands in the regfile before the read.
                    sel = FWD_RF;
                end
            end
            fwd_nxt[i] = sel;
        end
    end

    always_comb begin
        ex_nxt           = '0;
        ex_nxt.valid     = 1'b1;
        ex_nxt.rd        = bus.id_rd;
        // Multi-cycle results are tracked by the mc unit, not forwarded.
        ex_nxt.reg_write = bus.id_reg_write & ~bus.id_is_mc;
        ex_nxt.is_load   = bus.id_is_load;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            fwd_q <= '0;
        end else begin
            mem_q <= ex_q;
            wb_q  <= mem_q;
            if (issue) begin
                ex_q  <= ex_nxt;
                fwd_q <= fwd_nxt;
            end else begin
                ex_q  <= '0;
                fwd_q <= '0;
            end
        end
    end

    hazard_mc_tracker #(
        .LAT_W (LAT_W)
    ) u_mc (
        .clk     (clk),
        .rst     (rst),
        .start   (issue & bus.id_is_mc),
        .lat     (bus.id_mc_lat),
        .rd      (bus.id_rd),
        .busy    (mc_busy),
        .done    (mc_done),
        .busy_rd (mc_rd)
    );

    assign bus.stall      = stall;
    assign bus.ex_fwd_sel = fwd_q;
    assign bus.mc_busy    = mc_busy;
    assign bus.mc_done    = mc_done;
    assign bus.mc_rd      = mc_rd;

`ifdef HAZARD_PERF_CNT_EN
    // A cycle with both causes is charged to load-use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_lu_stalls <= '0;
            perf_mc_stalls <= '0;
        end else if (stall) begin
            if (lu_hit) begin
                if (perf_lu_stalls != '1) begin
                    perf_lu_stalls <= perf_lu_stalls + 32'd1;
                end
            end else if (perf_mc_stalls != '1) begin
                perf_mc_stalls <= perf_mc_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed ID stimulus pushes
// expected responses; a negedge monitor pops and compares them.
module tb_hazard_scoreboard;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NUM_SRC(2), .LAT_W(5)) bus ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_lu_stalls;
    logic [31:0] perf_mc_stalls;
`endif

    hazard_scoreboard #(
        .NUM_SRC (2),
        .LAT_W   (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_lu_stalls (perf_lu_stalls),
        .perf_mc_stalls (perf_mc_stalls)
`endif
    );

    // -1 in any field means "not checked this cycle".
    typedef struct {
        string nm;
        int    s;
        int    f;
        int    b;
        int    d;
        int    r;
        int    lu;
        int    mcp;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   p_lu  = -1;
    int   p_mc  = -1;

    task automatic chk(input string nm, input string fld, input int want, input int got);
        if (want >= 0) begin
            n_cmp++;
            if (got != want) begin
                n_bad++;
                $display("FAIL %s.%s: got %0d want %0d", nm, fld, got, want);
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk(e.nm, "stall", e.s, int'(bus.stall));
            chk(e.nm, "fwd", e.f, int'(bus.ex_fwd_sel));
            chk(e.nm, "mc_busy", e.b, int'(bus.mc_busy));
            chk(e.nm, "mc_done", e.d, int'(bus.mc_done));
            chk(e.nm, "mc_rd", e.r, int'(bus.mc_rd));
`ifdef HAZARD_PERF_CNT_EN
            chk(e.nm, "perf_lu", e.lu, int'(perf_lu_stalls));
            chk(e.nm, "perf_mc", e.mcp, int'(perf_mc_stalls));
`endif
        end
    end

    task automatic id(
        input logic       v,
        input logic [4:0] rs0,
        input logic [4:0] rs1,
        input logic [1:0] used,
        input logic [4:0] rd,
        input logic       rw,
        input logic       ld,
        input logic       mc,
        input logic [4:0] lat,
        input logic       fl
    );
        bus.id_valid     = v;
        bus.id_rs[0]     = rs0;
        bus.id_rs[1]     = rs1;
        bus.id_rs_used   = used;
        bus.id_rd        = rd;
        bus.id_reg_write = rw;
        bus.id_is_load   = ld;
        bus.id_is_mc     = mc;
        bus.id_mc_lat    = lat;
        bus.flush        = fl;
    endtask

    task automatic nop();
        id(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    // Queue the expectation for this cycle, then advance one clock.
    task automatic ex(input string nm, input int s, input int f,
                      input int b, input int d, input int r);
        exp_t e;
        e.nm  = nm;
        e.s   = s;
        e.f   = f;
        e.b   = b;
        e.d   = d;
        e.r   = r;
        e.lu  = p_lu;
        e.mcp = p_mc;
        p_lu  = -1;
        p_mc  = -1;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        nop();
        repeat (2) @(posedge clk);
        #1;
        id(1, 0, 0, 2'b00, 0, 0, 0, 1, 3, 0);
        p_lu = 0;
        p_mc = 0;
        ex("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        // add x5; add x6,x5,x5
        id(1, 1, 2, 2'b11, 5, 1, 0, 0, 0, 0);
        ex("add_x5", 0, 0, 0, 0, -1);
        id(1, 5, 5, 2'b11, 6, 1, 0, 0, 0, 0);
        ex("add_x6_id", 0, 0, -1, -1, -1);
        nop();
        ex("add_x6_fwd", 0, 4'b1010, -1, -1, -1);

        // lw x5; sub x7,x5,x1
        id(1, 1, 0, 2'b01, 5, 1, 1, 0, 0, 0);
        ex("lw_x5", 0, 0, -1, -1, -1);
        id(1, 5, 1, 2'b11, 7, 1, 0, 0, 0, 0);
        ex("lu_stall", 1, 0, -1, -1, -1);
        ex("lu_release", 0, 0, -1, -1, -1);
        nop();
        ex("lu_fwd", 0, 4'b0001, -1, -1, -1);

        // mul x9 lat 4; add x2,x9,x0
        id(1, 1, 2, 2'b11, 9, 1, 0, 1, 4, 0);
        ex("mul_issue", 0, -1, 0, 0, -1);
        id(1, 9, 0, 2'b11, 2, 1, 0, 0, 0, 0);
        ex("mc_stall1", 1, -1, 1, 0, 9);
        ex("mc_stall2", 1, -1, 1, 0, 9);
        ex("mc_stall3", 1, -1, 1, 0, 9);
        ex("mc_done", 0, -1, 1, 1, 9);
        nop();
        ex("mc_after", 0, 0, 0, 0, -1);

        // div x10 lat 2; mul x11 lat 1 waits for it
        id(1, 3, 4, 2'b11, 10, 1, 0, 1, 2, 0);
        ex("div_issue", 0, -1, 0, 0, -1);
        id(1, 1, 2, 2'b11, 11, 1, 0, 1, 1, 0);
        ex("mc_mc_stall", 1, -1, 1, 0, 10);
        ex("mc_mc_go", 0, -1, 1, 1, 10);
        nop();
        ex("mul_lat1", 0, -1, 1, 1, 11);
        ex("mul_lat1_clr", 0, -1, 0, 0, -1);

        // latency 0 behaves as 1
        id(1, 1, 2, 2'b11, 4, 1, 0, 1, 0, 0);
        ex("lat0_issue", 0, -1, 0, 0, -1);
        nop();
        ex("lat0_done", 0, -1, 1, 1, 4);
        ex("lat0_clr", 0, -1, 0, 0, -1);

        // flush during load-use stall
        id(1, 1, 0, 2'b01, 12, 1, 1, 0, 0, 0);
        ex("lw_x12", 0, 0, -1, -1, -1);
        id(1, 12, 12, 2'b11, 13, 1, 0, 0, 0, 1);
        ex("flush_stall", 0, 0, -1, -1, -1);
        nop();
        ex("flush_bubble", 0, 0, -1, -1, -1);

        // x0 never stalls or forwards
        id(1, 1, 0, 2'b01, 0, 1, 1, 0, 0, 0);
        ex("lw_x0", 0, -1, -1, -1, -1);
        id(1, 0, 0, 2'b11, 3, 1, 0, 0, 0, 0);
        ex("x0_load", 0, -1, -1, -1, -1);
        id(1, 1, 0, 2'b01, 0, 1, 0, 0, 0, 0);
        ex("add_x0", 0, 0, -1, -1, -1);
        id(1, 0, 0, 2'b11, 3, 1, 0, 0, 0, 0);
        ex("x0_alu", 0, -1, -1, -1, -1);
        nop();
        ex("x0_fwd", 0, 0, -1, -1, -1);

        // reset mid mc-op at count 2
        id(1, 1, 2, 2'b11, 9, 1, 0, 1, 4, 0);
        ex("mul2_issue", 0, -1, 0, 0, -1);
        nop();
        ex("mul2_busy", 0, -1, 1, 0, 9);
        rst = 1'b1;
        id(1, 9, 0, 2'b11, 2, 1, 0, 1, 1, 0);
        ex("rst_mid", 0, 0, 0, 0, 0);
        rst = 1'b0;
        nop();
        ex("no_done1", 0, -1, 0, 0, -1);
        ex("no_done2", 0, -1, 0, 0, -1);
        ex("no_done3", 0, -1, 0, 0, -1);

        // one load-use stall after reset
        id(1, 1, 0, 2'b01, 5, 1, 1, 0, 0, 0);
        ex("perf_lw", 0, -1, -1, -1, -1);
        id(1, 5, 1, 2'b11, 7, 1, 0, 0, 0, 0);
        ex("perf_stall", 1, -1, -1, -1, -1);
        p_lu = 1;
        p_mc = 0;
        ex("perf_release", 0, -1, -1, -1, -1);
        nop();

        for (int k = 0; k < 10 && q.size() != 0; k++) begin
            @(negedge clk);
        end
        #1;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NUM_SRC, default 2, number of source operands checked per instruction (1..3).
REQ-002 Parameter LAT_W, default 5, width of the multi-cycle latency field.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 id_valid  input  1  a valid instruction is in ID.
REQ-006 id_rs  input  NUM_SRC x 5  source register addresses.
REQ-007 id_rs_used  input  NUM_SRC  per-source "operand is read".
REQ-008 id_rd, id_reg_write  input  5, 1  destination address and write enable.
REQ-009 id_is_load, id_is_mc  input  1, 1  load, or multi-cycle (mul/div) op.
REQ-010 id_mc_lat  input  LAT_W  multi-cycle latency in cycles.
REQ-011 flush  input  1  branch/jump flush of ID.
REQ-012 stall  output  1  combinational; hold PC and IF/ID, insert a bubble into EX.
REQ-013 ex_fwd_sel  output  NUM_SRC x 2  registered ALU-input mux select for the instruction now in EX: 00 regfile, 10 EX/MEM, 01 MEM/WB.
REQ-014 mc_busy, mc_done, mc_rd  output  1, 1, 5  multi-cycle unit occupied; one-cycle completion pulse; destination of the completing op.

Function
REQ-015 The block SHALL keep internal EX, MEM and WB shadow entries {valid, rd, reg_write, is_load}; MEM<=EX and WB<=MEM every cycle.
REQ-016 EX SHALL load the ID instruction when id_valid & !stall & !flush, otherwise a bubble (valid=0); multi-cycle ops enter EX with reg_write=0.
REQ-017 stall SHALL assert when id_valid & !flush and any of: a used nonzero source equals a valid EX load rd (load-use); a used source, or id_rd when id_reg_write, equals mc_rd while mc_busy & !mc_done; id_is_mc while mc_busy & !mc_done.
REQ-018 On each EX load, for each source, ex_fwd_sel SHALL become 10 if used, rs!=0 and rs equals a valid writing EX rd; else 01 on the same match against MEM; else 00; the EX match wins.
REQ-019 ex_fwd_sel SHALL become 00 whenever EX receives a bubble.
REQ-020 A WB-stage match SHALL need no forwarding; the regfile is write-before-read.
REQ-021 An mc op entering EX at edge T with latency L SHALL set mc_busy and mc_rd at T and pulse mc_done in the cycle after edge T+L-1; L=0 is treated as 1.
REQ-022 mc_busy SHALL clear on the edge that ends the mc_done cycle; an ID source equal to mc_rd during the mc_done cycle SHALL NOT stall.
REQ-023 flush SHALL take precedence over stall and issue; it SHALL NOT affect MEM, WB or an in-flight mc op.
REQ-024 Register x0 SHALL never cause a stall or forward.

Reset
REQ-025 rst SHALL clear all shadow valids, ex_fwd_sel=00, mc_busy=0, mc_done=0, mc_rd=0 and the mc counter; stall=0 while rst is asserted.
REQ-026 Reset asserted mid mc-op SHALL abandon it with no mc_done pulse.

Configuration
REQ-027 With HAZARD_PERF_CNT_EN defined, the block SHALL add outputs perf_lu_stalls and perf_mc_stalls (32 bits, saturating, cleared by rst), counting cycles of load-use and mc-caused stall; when both causes hold, the load-use counter is incremented.
REQ-028 Without HAZARD_PERF_CNT_EN, those ports and counters SHALL be absent and behaviour is otherwise identical.

Structure
REQ-029 Package hazard_pkg SHALL hold the fwd_sel enum (FWD_RF, FWD_MEM_WB, FWD_EX_MEM), the shadow-entry struct and REG_ADDR_W=5.
REQ-030 The latency counter, mc_busy/mc_done/mc_rd SHALL live in sub-module hazard_mc_tracker.

Verification
REQ-031 Bench scenarios:
- add x5 then add x6,x5,x5 back-to-back -> no stall; ex_fwd_sel=10,10 for the second instruction.
- lw x5; sub x7,x5,x1 -> stall 1 cycle; then ex_fwd_sel[0]=01, [1]=00.
- mul x9 with lat 4 issued at edge T; then add x2,x9,x0 -> stall until the mc_done cycle (after edge T+3); the add issues with ex_fwd_sel=00.
- second mc op while mc_busy -> stall until mc_done; flush during a load-use stall -> stall=0 and EX receives a bubble.
- sources x0 with EX rd=x0 writing -> no stall, select 00.
- rst asserted mid mc-op at count 2 -> mc_busy=0 and no mc_done pulse; with HAZARD_PERF_CNT_EN, one load-use stall yields perf_lu_stalls=1.
